// File: rtl/mac_result_accum_pkg.sv
// mac_result_accum_pkg: shared widths, FSM encoding and saturation constant for the MAC result accumulator.
package mac_result_accum_pkg;
  localparam int INW_DEF = 18;
  localparam int ACCW_DEF = 32;
  localparam int LENW_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 2;
  localparam int IDXW_DEF = 8;
  typedef enum logic {ST_IDLE, ST_ACC} state_t;
  function automatic logic [63:0] acc_max(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction
endpackage

// File: rtl/mac_result_accum_fifo.sv
// result_fifo: synchronous FIFO with flush, flop-based storage and push accepted on full when a pop frees the head.
module result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign valid = cnt_q != '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign do_pop = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign rdata = mem_q[rd_q];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata;
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/mac_result_accum.sv
// mac_result_accum: accumulates a programmable number of MAC beats into a saturating result and queues it for readout.
module mac_result_accum
  import mac_result_accum_pkg::*;
#(
  parameter int INW = INW_DEF,
  parameter int ACCW = ACCW_DEF,
  parameter int LENW = LENW_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int IDXW = IDXW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            soft_clr,
  input  logic [LENW-1:0] cfg_len,
  input  logic            in_valid,
  input  logic [INW-1:0]  in_sum,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] out_acc,
  output logic            out_sat,
  output logic [IDXW-1:0] out_idx,
  output logic            busy,
  output logic            ovf_err
);
  localparam logic [ACCW-1:0] ACC_MAX = ACCW'(acc_max(ACCW));
  localparam int W = ACCW + 1 + IDXW;
  state_t state_q;
  logic [ACCW-1:0] acc_q, acc_d;
  logic sat_q, sat_d, ovf_q;
  logic [LENW-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [IDXW-1:0] idx_q;
  logic [ACCW:0] sum;
  logic first, over, done, push, full;
  logic [W-1:0] rdata;
  always_comb begin
    first = state_q == ST_IDLE;
    sum = {1'b0, (first ? {ACCW{1'b0}} : acc_q)} + (ACCW+1)'(in_sum);
    over = sum[ACCW];
    acc_d = over ? ACC_MAX : sum[ACCW-1:0];
    sat_d = over || (!first && sat_q);
    len_d = first ? (cfg_len == '0 ? LENW'(1) : cfg_len) : len_q;
    cnt_d = first ? LENW'(1) : cnt_q + 1'b1;
    done = cnt_d == len_d;
    push = in_valid && !soft_clr && done;
  end
  // idx advances on every push attempt so dropped results leave a visible gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q <= '0;
      sat_q <= 1'b0;
      cnt_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      ovf_q <= 1'b0;
    end else if (soft_clr) begin
      state_q <= ST_IDLE;
      acc_q <= '0;
      sat_q <= 1'b0;
      cnt_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (in_valid) begin
        state_q <= done ? ST_IDLE : ST_ACC;
        acc_q <= acc_d;
        sat_q <= sat_d;
        cnt_q <= cnt_d;
        len_q <= len_d;
      end
      if (push) idx_q <= idx_q + 1'b1;
      if (push && full && !out_ready) ovf_q <= 1'b1;
    end
  end
  result_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clr(soft_clr),
    .push(push),
    .pop(out_ready),
    .wdata({acc_d, sat_d, idx_q}),
    .rdata(rdata),
    .valid(out_valid),
    .full(full)
  );
  assign {out_acc, out_sat, out_idx} = rdata;
  assign busy = state_q == ST_ACC;
  assign ovf_err = ovf_q;
endmodule
